// File: rtl/poly1305_pkg.sv
// rtl/poly1305_pkg.sv - shared constants, FSM states and digit-count helper for poly1305_digit
//   P1305      : the Poly1305 prime 2^130-5
//   CLAMP_MASK : r clamp mask, applied only when POLY1305_CLAMP_EN is defined
//   state_e    : block-processing FSM states
//   ndig()     : number of multiply cycles for a given digit width
package poly1305_pkg;

   localparam logic [129:0] P1305      = {2'b11, {31{4'hf}}, 4'hb};
   localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_MUL,
      ST_RED,
      ST_FIN
   } state_e;

   function automatic int ndig(input int digit_w);
      return 128 / digit_w;
   endfunction

endpackage

// File: rtl/poly1305_digit_mac.sv
// rtl/poly1305_digit_mac.sv - one digit-serial multiply step with fold-by-5 partial reduction
//   acc_i   : running accumulator, below 2^131
//   a_i     : multiplicand h'+c, below 2^131
//   digit_i : current DIGIT_W-bit digit of r
//   acc_o   : (acc_i*2^DIGIT_W + a_i*digit_i) folded once, below 2^131
module poly1305_digit_mac
   import poly1305_pkg::*;
#(
   parameter int DIGIT_W = 8
) (
   input  logic [130:0]         acc_i,
   input  logic [130:0]         a_i,
   input  logic [DIGIT_W-1:0]   digit_i,
   output logic [130:0]         acc_o
);

   // Raw sum is below 2^(132+DIGIT_W); bits at and above 2^130 fold back
   // with weight 5. For DIGIT_W <= 64 one fold keeps the result below 2^131.
   localparam int FW = 132 + DIGIT_W;

   logic [FW-1:0]      full;
   logic [DIGIT_W+1:0] hi;
   logic [130:0]       folded;

   always_comb begin
      full   = (FW'(acc_i) << DIGIT_W) + FW'(a_i) * FW'(digit_i);
      hi     = full[FW-1:130];
      folded = {1'b0, full[129:0]} + 131'(hi) * 131'd5;
   end

   assign acc_o = folded;

endmodule

// File: rtl/poly1305_digit.sv
// rtl/poly1305_digit.sv - digit-serial Poly1305 block engine (optional macro POLY1305_CLAMP_EN)
//   clk, reset        : clock, synchronous active-high reset
//   r, s              : key halves, little-endian numbers
//   m, blen           : message block and valid byte count (0 or >16 means 16)
//   ld, first, last   : load strobe (taken only when rdy), message start/end flags
//   p, rdy, tag_vld   : tag output, idle indication, tag valid
module poly1305_digit
   import poly1305_pkg::*;
#(
   parameter int DIGIT_W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] r,
   input  logic [127:0] s,
   input  logic [127:0] m,
   input  logic [4:0]   blen,
   input  logic         ld,
   input  logic         first,
   input  logic         last,
   output logic [127:0] p,
   output logic         rdy,
   output logic         tag_vld
);

   localparam int         NDIG     = ndig(DIGIT_W);
   localparam logic [7:0] CNT_LAST = 8'(NDIG - 1);

   state_e       state_q;
   logic [127:0] r_q, s_q, m_q, p_q;
   logic [4:0]   blen_q;
   logic         first_q, last_q, tag_vld_q, rdy_q;
   logic [130:0] a_q, acc_q;
   logic [129:0] h_q;
   logic [7:0]   cnt_q;

   logic [127:0] r_load;
   logic [4:0]   nbytes;
   logic [128:0] c_d;
   logic [130:0] a_d, acc_d, fold_d;
   logic [129:0] h_d;
   logic [127:0] p_d;

`ifdef POLY1305_CLAMP_EN
   assign r_load = r & CLAMP_MASK;
`else
   assign r_load = r;
`endif

   always_comb begin
      nbytes = (blen_q == 5'd0 || blen_q > 5'd16) ? 5'd16 : blen_q;
      // c = valid bytes of m plus the pad bit just above them
      c_d = '0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < nbytes) c_d[8*i +: 8] = m_q[8*i +: 8];
      end
      c_d[{nbytes, 3'b000}] = 1'b1;
      a_d = (first_q ? 131'd0 : {1'b0, h_q}) + {2'b00, c_d};
      // acc < 2^131: one fold gives < 2^130+5, then at most one subtract of p
      fold_d = {1'b0, acc_q[129:0]} + (acc_q[130] ? 131'd5 : 131'd0);
      h_d    = (fold_d >= {1'b0, P1305}) ? 130'(fold_d - {1'b0, P1305}) : fold_d[129:0];
      p_d    = h_q[127:0] + s_q;
   end

   poly1305_digit_mac #(
      .DIGIT_W (DIGIT_W)
   ) u_mac (
      .acc_i   (acc_q),
      .a_i     (a_q),
      .digit_i (r_q[127 -: DIGIT_W]),
      .acc_o   (acc_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         r_q       <= '0;
         s_q       <= '0;
         m_q       <= '0;
         blen_q    <= '0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         a_q       <= '0;
         acc_q     <= '0;
         h_q       <= '0;
         cnt_q     <= '0;
         p_q       <= '0;
         tag_vld_q <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ld) begin
                  r_q       <= r_load;
                  s_q       <= s;
                  m_q       <= m;
                  blen_q    <= blen;
                  first_q   <= first;
                  last_q    <= last;
                  tag_vld_q <= 1'b0;
                  rdy_q     <= 1'b0;
                  state_q   <= ST_ADD;
               end
            end
            ST_ADD: begin
               a_q     <= a_d;
               acc_q   <= '0;
               cnt_q   <= CNT_LAST;
               state_q <= ST_MUL;
            end
            ST_MUL: begin
               // r digits are consumed from the top, so shift r up each cycle
               acc_q <= acc_d;
               r_q   <= r_q << DIGIT_W;
               if (cnt_q == 8'd0) state_q <= ST_RED;
               else               cnt_q   <= cnt_q - 8'd1;
            end
            ST_RED: begin
               h_q <= h_d;
               if (last_q) begin
                  state_q <= ST_FIN;
               end else begin
                  state_q <= ST_IDLE;
                  rdy_q   <= 1'b1;
               end
            end
            ST_FIN: begin
               p_q       <= p_d;
               tag_vld_q <= 1'b1;
               rdy_q     <= 1'b1;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign p       = p_q;
   assign rdy     = rdy_q;
   assign tag_vld = tag_vld_q;

endmodule

// File: tb/tb_poly1305_digit.sv
// tb/tb_poly1305_digit.sv - scoreboard bench for poly1305_digit over DIGIT_W 8, 1, 16, 64
module tb_poly1305_digit;

   localparam logic [129:0] PRIME   = {2'b11, {31{4'hf}}, 4'hb};
   localparam logic [127:0] RFC_R   = 128'h0806d5400e52447c036d555408bed685;
   localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
   localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
   localparam logic [127:0] RFC_M1  = 128'h6f4620636968706172676f7470797243;
   localparam logic [127:0] RFC_M2  = 128'h6f7247206863726165736552206d7572;
   localparam logic [127:0] RFC_M3  = 128'hdeadbeefcafef00d1234567890ab7075;

   function automatic int dw_of(input int g);
      case (g)
         0:       return 8;
         1:       return 1;
         2:       return 16;
         default: return 64;
      endcase
   endfunction

   typedef struct {
      int           k;
      logic [127:0] tag;
   } exp_t;

   logic               clk;
   logic [3:0]         rst_r, ld_r;
   logic [127:0]       r_in, s_in, m_in;
   logic [4:0]         blen_in;
   logic               first_in, last_in;
   logic [3:0]         rdy_w, tag_w;
   logic [3:0][127:0]  p_w;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      poly1305_digit #(
         .DIGIT_W (dw_of(g))
      ) u_dut (
         .clk     (clk),
         .reset   (rst_r[g]),
         .r       (r_in),
         .s       (s_in),
         .m       (m_in),
         .blen    (blen_in),
         .ld      (ld_r[g]),
         .first   (first_in),
         .last    (last_in),
         .p       (p_w[g]),
         .rdy     (rdy_w[g]),
         .tag_vld (tag_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int k, input logic [127:0] tag);
      exp_t e;
      e.k   = k;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   function automatic logic [129:0] mdl_step(input logic [129:0] h, input logic [127:0] rr,
                                             input logic [127:0] mm, input logic [4:0] bl,
                                             input logic fi);
      logic [263:0] acc, c;
      int n;
      n = (bl == 5'd0 || bl > 5'd16) ? 16 : int'(bl);
      c = '0;
      for (int i = 0; i < n; i++) c[8*i +: 8] = mm[8*i +: 8];
      c[8*n] = 1'b1;
      acc = (fi ? 264'd0 : {134'd0, h}) + c;
      acc = acc * {136'd0, rr};
      acc = acc % {134'd0, PRIME};
      return acc[129:0];
   endfunction

   // Monitor: every rising tag_vld must match the oldest expected tag
   initial begin
      logic [3:0] prev;
      exp_t       e;
      prev = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (tag_w[k] && !prev[k]) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_tag: dut %0d p=%h with none expected", k, p_w[k]);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("tag_src_dut%0d", k), 128'(k), 128'(e.k));
                  check($sformatf("tag_dut%0d", k), p_w[k], e.tag);
               end
            end
            prev[k] = tag_w[k];
         end
      end
   end

   task automatic wait_rdy(input int k);
      int n = 0;
      while (rdy_w[k] !== 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (rdy_w[k] !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_rdy_dut%0d: rdy=%b required 1 within 400 cycles", k, rdy_w[k]);
      end
   endtask

   task automatic send_block(input int k, input logic [127:0] mm, input logic [4:0] bl,
                             input logic fi, input logic la, input bit noisy);
      int n;
      int want;
      wait_rdy(k);
      m_in     = mm;
      blen_in  = bl;
      first_in = fi;
      last_in  = la;
      ld_r[k]  = 1'b1;
      @(posedge clk); #1;
      ld_r[k] = 1'b0;
      n = 0;
      while (rdy_w[k] !== 1'b1 && n < 400) begin
         if (noisy) ld_r[k] = ~ld_r[k];
         @(posedge clk); #1;
         n++;
      end
      ld_r[k] = 1'b0;
      want = 128 / dw_of(k) + 2 + (la ? 1 : 0);
      check($sformatf("latency_dut%0d", k), 128'(n), 128'(want));
   endtask

   task automatic send_rfc(input int k, input bit noisy);
      r_in = RFC_R;
      s_in = RFC_S;
      push_exp(k, RFC_TAG);
      send_block(k, RFC_M1, 5'd16, 1'b1, 1'b0, noisy);
      send_block(k, RFC_M2, 5'd16, 1'b0, 1'b0, noisy);
      send_block(k, RFC_M3, 5'd2,  1'b0, 1'b1, noisy);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [129:0] h;
      logic [127:0] ra, sa, ma1, ma2;
      rst_r    = '1;
      ld_r     = '1;
      r_in     = '0;
      s_in     = '0;
      m_in     = '0;
      blen_in  = 5'd16;
      first_in = 1'b0;
      last_in  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_r = '0;
      ld_r  = '0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("reset_rdy_dut%0d", k), 128'(rdy_w[k]), 128'd1);
         check($sformatf("reset_tag_vld_dut%0d", k), 128'(tag_w[k]), 128'd0);
         check($sformatf("reset_p_dut%0d", k), p_w[k], 128'd0);
      end

      // RFC vector on every digit width, then tag must hold while idle
      for (int k = 0; k < 4; k++) begin
         send_rfc(k, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("hold_p_dut%0d", k), p_w[k], RFC_TAG);
         check($sformatf("hold_tag_vld_dut%0d", k), 128'(tag_w[k]), 128'd1);
      end

      // ld toggled while busy is ignored
      send_rfc(0, 1'b1);

      // r = 0 gives p = s
      r_in = '0;
      s_in = 128'h0123456789abcdef0123456789abcdef;
      push_exp(0, s_in);
      send_block(0, 128'hffffeeeeddddccccbbbbaaaa99998888, 5'd16, 1'b1, 1'b1, 1'b0);

      // Reset in MUL cycle 5 of block 2, with ld held on the reset edge
      r_in = RFC_R;
      s_in = RFC_S;
      send_block(0, RFC_M1, 5'd16, 1'b1, 1'b0, 1'b0);
      check("tag_vld_cleared_on_ld", 128'(tag_w[0]), 128'd0);
      wait_rdy(0);
      m_in     = RFC_M2;
      blen_in  = 5'd16;
      first_in = 1'b0;
      last_in  = 1'b0;
      ld_r[0]  = 1'b1;
      @(posedge clk); #1;
      ld_r[0] = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_r[0] = 1'b1;
      ld_r[0]  = 1'b1;
      @(posedge clk); #1;
      rst_r[0] = 1'b0;
      ld_r[0]  = 1'b0;
      check("abort_rdy", 128'(rdy_w[0]), 128'd1);
      check("abort_tag_vld", 128'(tag_w[0]), 128'd0);
      check("abort_p", p_w[0], 128'd0);
      @(posedge clk); #1;
      check("abort_ld_dropped", 128'(rdy_w[0]), 128'd1);
      send_rfc(0, 1'b0);

      // Two back-to-back messages: blen=0 block, junk above blen, s wrap-around
      ra  = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
      sa  = '1;
      ma1 = '1;
      ma2 = 128'h0123456789abcdef00000000000000a5;
      h   = mdl_step(130'd0, ra, ma1, 5'd0, 1'b1);
      h   = mdl_step(h, ra, ma2, 5'd1, 1'b0);
      r_in = ra;
      s_in = sa;
      push_exp(0, h[127:0] + sa);
      send_block(0, ma1, 5'd0, 1'b1, 1'b0, 1'b0);
      send_block(0, ma2, 5'd1, 1'b0, 1'b1, 1'b0);
      send_rfc(0, 1'b0);

      repeat (10) @(posedge clk);
      #1;
      check("pending_tags", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
